// File: rtl/cpu_types_pkg.sv
// Shared types for the memory subsystem: RAM handshake states, word type and
// the cache/RAM arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ram_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache: dcache has priority, and a
// starvation counter forces an icache grant after STARVE_MAX dcache wins.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    // Handshake: a side's request is held until its wait drops for one cycle
    // (completion) or the side withdraws it (abort). A grant is held to the
    // end of its transaction; IDLE always separates two grants.

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    ram_state_t rs;
    logic       ram_done;
    logic       ram_err;
    logic       d_req;

    assign rs       = ram_state_t'(ramstate);
    assign ram_done = (rs == ACCESS) || (rs == ERROR);
    assign ram_err  = (rs == ERROR);
    assign d_req    = dREN || dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (iREN && (starve_cnt_q == STARVE_LIM)) begin
                    state_d = ISERV;
                end else if (d_req) begin
                    state_d = DSERV;
                    if (iREN && (starve_cnt_q != STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end else if (iREN) begin
                    state_d = ISERV;
                end
            end
            ISERV: begin
                // Withdrawal aborts without touching the counter.
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_done) begin
                    state_d      = IDLE;
                    starve_cnt_d = '0;
                end
            end
            DSERV: begin
                if (!d_req || ram_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        arb_err  = 1'b0;
        unique case (state_q)
            ISERV: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                if (iREN && ram_done) begin
                    iwait   = 1'b0;
                    arb_err = ram_err;
                end
            end
            DSERV: begin
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                if (d_req && ram_done) begin
                    dwait   = 1'b0;
                    arb_err = ram_err;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs change on the falling edge and
// outputs are sampled 1ns later, so each check sees one settled cycle.
module tb_cache_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    cache_mem_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h40; daddr = 32'h80; dstore = 32'h1234;
        ramload = 32'hFFFF_FFFF; ramstate = RS_ACCESS;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK); #1;
            n_checks++;
            if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
                n_fail++; $display("FAIL reset_en: ren=%b wen=%b expected 0 0", ramREN, ramWEN);
            end
            n_checks++;
            if (iwait !== 1'b1 || dwait !== 1'b1) begin
                n_fail++; $display("FAIL reset_wait: iwait=%b dwait=%b expected 1 1", iwait, dwait);
            end
            n_checks++;
            if (iload !== 32'h0 || dload !== 32'h0 || ramaddr !== 32'h0 || ramstore !== 32'h0 || arb_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_data: iload=%h dload=%h addr=%h store=%h err=%b expected all 0",
                         iload, dload, ramaddr, ramstore, arb_err);
            end
        end
        @(negedge CLK);
        nRST = 1'b1; iREN = 1'b0; dREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++;
        if (dut.state_q !== 2'd0 || dut.starve_cnt_q !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: state=%0d cnt=%0d expected 0 0", dut.state_q, dut.starve_cnt_q);
        end
    endtask

    task automatic test_icache_read();
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h40; ramstate = RS_BUSY; ramload = 32'h0;
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            n_fail++; $display("FAIL iread_idle: ren=%b iwait=%b expected 0 1", ramREN, iwait);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK); #1;
            n_checks++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
                n_fail++; $display("FAIL iread_busy: ren=%b addr=%h iwait=%b expected 1 40 1", ramREN, ramaddr, iwait);
            end
        end
        @(negedge CLK);
        ramstate = RS_ACCESS; ramload = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (iwait !== 1'b0 || iload !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL iread_done: iwait=%b iload=%h expected 0 deadbeef", iwait, iload);
        end
        n_checks++;
        if (dwait !== 1'b1 || dload !== 32'h0 || arb_err !== 1'b0) begin
            n_fail++; $display("FAIL iread_dside: dwait=%b dload=%h err=%b expected 1 0 0", dwait, dload, arb_err);
        end
        @(negedge CLK);
        iREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++;
        if (iwait !== 1'b1 || ramREN !== 1'b0) begin
            n_fail++; $display("FAIL iread_after: iwait=%b ren=%b expected 1 0", iwait, ramREN);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h40;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        ramstate = RS_BUSY; ramload = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin
            n_fail++; $display("FAIL sim_idle: wen=%b ren=%b expected 0 0", ramWEN, ramREN);
        end
        @(negedge CLK); #1;
        n_checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'h1234) begin
            n_fail++;
            $display("FAIL sim_dwrite: wen=%b ren=%b addr=%h store=%h expected 1 0 80 1234",
                     ramWEN, ramREN, ramaddr, ramstore);
        end
        n_checks++;
        if (iwait !== 1'b1 || iload !== 32'h0) begin
            n_fail++; $display("FAIL sim_iside: iwait=%b iload=%h expected 1 0", iwait, iload);
        end
        @(negedge CLK);
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if (dwait !== 1'b0 || iwait !== 1'b1) begin
            n_fail++; $display("FAIL sim_ddone: dwait=%b iwait=%b expected 0 1", dwait, iwait);
        end
        @(negedge CLK);
        dWEN = 1'b0; ramstate = RS_BUSY;
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin
            n_fail++; $display("FAIL sim_gap: ren=%b wen=%b dwait=%b expected 0 0 1", ramREN, ramWEN, dwait);
        end
        @(negedge CLK);
        ramstate = RS_ACCESS; ramload = 32'h0000_CAFE;
        #1;
        n_checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b0 || iload !== 32'h0000_CAFE || dload !== 32'h0) begin
            n_fail++;
            $display("FAIL sim_iserv: ren=%b addr=%h iwait=%b iload=%h dload=%h expected 1 40 0 cafe 0",
                     ramREN, ramaddr, iwait, iload, dload);
        end
        @(negedge CLK);
        iREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++;
        if (dut.starve_cnt_q !== 3'd0) begin
            n_fail++; $display("FAIL sim_cnt: cnt=%0d expected 0", dut.starve_cnt_q);
        end
    endtask

    task automatic test_starvation();
        int  order_q[$];
        bit  i_seen;
        i_seen = 1'b0;
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h200;
        ramstate = RS_ACCESS; ramload = 32'h55;
        for (int c = 0; c < 20 && !i_seen; c++) begin
            if (c != 0) @(negedge CLK);
            #1;
            if (!dwait) order_q.push_back(0);
            if (!iwait) begin
                order_q.push_back(1);
                i_seen = 1'b1;
            end
        end
        n_checks++;
        if (!i_seen) begin
            n_fail++; $display("FAIL starve_timeout: no icache completion within 20 cycles, got %0d completions", order_q.size());
        end
        n_checks++;
        if (order_q.size() != 5) begin
            n_fail++; $display("FAIL starve_count: completions=%0d expected 5", order_q.size());
        end else begin
            n_checks++;
            if (order_q[0] != 0 || order_q[1] != 0 || order_q[2] != 0 || order_q[3] != 0 || order_q[4] != 1) begin
                n_fail++;
                $display("FAIL starve_order: %0d%0d%0d%0d%0d expected 00001 (0=dcache 1=icache)",
                         order_q[0], order_q[1], order_q[2], order_q[3], order_q[4]);
            end
        end
        @(negedge CLK);
        iREN = 1'b0; dREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++;
        if (dut.starve_cnt_q !== 3'd0 || dut.state_q !== 2'd0) begin
            n_fail++; $display("FAIL starve_clear: cnt=%0d state=%0d expected 0 0", dut.starve_cnt_q, dut.state_q);
        end
    endtask

    task automatic test_abort();
        @(negedge CLK);
        dREN = 1'b1; daddr = 32'h300; ramstate = RS_BUSY;
        @(negedge CLK); #1;
        n_checks++;
        if (ramREN !== 1'b1 || dwait !== 1'b1) begin
            n_fail++; $display("FAIL abort_c1: ren=%b dwait=%b expected 1 1", ramREN, dwait);
        end
        @(negedge CLK);
        dREN = 1'b0;
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin
            n_fail++; $display("FAIL abort_drop: ren=%b wen=%b dwait=%b expected 0 0 1", ramREN, ramWEN, dwait);
        end
        @(negedge CLK);
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if (dut.state_q !== 2'd0 || dwait !== 1'b1 || dut.starve_cnt_q !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_idle: state=%0d dwait=%b cnt=%0d expected 0 1 0", dut.state_q, dwait, dut.starve_cnt_q);
        end
        ramstate = RS_FREE;
    endtask

    task automatic test_error();
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h44; ramstate = RS_BUSY;
        @(negedge CLK); #1;
        n_checks++;
        if (arb_err !== 1'b0 || iwait !== 1'b1) begin
            n_fail++; $display("FAIL err_busy: err=%b iwait=%b expected 0 1", arb_err, iwait);
        end
        @(negedge CLK);
        ramstate = RS_ERROR; ramload = 32'h0000_0BAD;
        #1;
        n_checks++;
        if (iwait !== 1'b0 || arb_err !== 1'b1 || iload !== 32'h0000_0BAD) begin
            n_fail++; $display("FAIL err_done: iwait=%b err=%b iload=%h expected 0 1 bad", iwait, arb_err, iload);
        end
        @(negedge CLK);
        iREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++;
        if (arb_err !== 1'b0 || iwait !== 1'b1 || dut.state_q !== 2'd0) begin
            n_fail++; $display("FAIL err_after: err=%b iwait=%b state=%0d expected 0 1 0", arb_err, iwait, dut.state_q);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        dREN = 1'b1; daddr = 32'h500; ramstate = RS_BUSY;
        @(negedge CLK); #1;
        n_checks++;
        if (ramREN !== 1'b1) begin
            n_fail++; $display("FAIL rmid_active: ren=%b expected 1", ramREN);
        end
        nRST = 1'b0;
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dut.state_q !== 2'd0) begin
            n_fail++; $display("FAIL rmid_drop: ren=%b addr=%h state=%0d expected 0 0 0", ramREN, ramaddr, dut.state_q);
        end
        @(negedge CLK);
        dREN = 1'b0; nRST = 1'b1; ramstate = RS_FREE;
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_simultaneous();
        test_starvation();
        test_abort();
        test_error();
        test_reset_mid();
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
